// File: rtl/screen_pkg.sv
// Shared command/state encodings and geometry for the screen buffer controller.
package screen_pkg;

    localparam int ROWS  = 32;
    localparam int COLS  = 32;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_SET       = 3'd1,
        CMD_CLR       = 3'd2,
        CMD_READ      = 3'd3,
        CMD_CLEAR_ALL = 3'd4,
        CMD_PUSH      = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_VBL = 2'd2,
        COPY     = 2'd3
    } state_e;

endpackage

// File: rtl/scr_row_seq.sv
// Row sequencer shared by CLEAR and COPY; flags the cycle the counter wraps 31 -> 0.
module scr_row_seq
    import screen_pkg::*;
(
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    input  logic             I_en,
    output logic [ROW_W-1:0] O_row,
    output logic             O_wrap
);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_row <= '0;
        end else if (I_en) begin
            O_row <= O_row + 1'b1;
        end
    end

    assign O_wrap = I_en && (O_row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/screen_buffer_ctrl.sv
// 32x32 monochrome draw buffer with pixel commands, bulk clear and a
// row-by-row copy into the registered display buffer, optionally vblank-synced.
module screen_buffer_ctrl
    import screen_pkg::*;
#(
    parameter bit SYNC_PUSH = 1'b1
) (
    input  logic                       I_pxl_clk,
    input  logic                       I_rst_n,
    input  logic                       I_cmd_valid,
    output logic                       O_cmd_ready,
    input  logic [2:0]                 I_cmd,
    input  logic [COL_W-1:0]           I_x,
    input  logic [ROW_W-1:0]           I_y,
    input  logic                       I_vblank,
    output logic                       O_rd_valid,
    output logic                       O_rd_data,
    output logic [ROWS-1:0][COLS-1:0]  O_buffer,
    output logic                       O_busy,
    output logic                       O_pushed
);

    state_e                    state;
    logic [ROWS-1:0][COLS-1:0] draw;
    logic [ROW_W-1:0]          row;
    logic                      row_en;
    logic                      row_wrap;
    logic [COL_W-1:0]          bit_idx;

    // Column 0 is the leftmost pixel, held in bit 31 of each row word.
    assign bit_idx     = COL_W'(COLS - 1) - I_x;
    assign row_en      = (state == CLEAR) || (state == COPY);
    assign O_cmd_ready = (state == IDLE);
    assign O_busy      = (state != IDLE);

    scr_row_seq u_row_seq (
        .I_pxl_clk (I_pxl_clk),
        .I_rst_n   (I_rst_n),
        .I_en      (row_en),
        .O_row     (row),
        .O_wrap    (row_wrap)
    );

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= IDLE;
            draw       <= '0;
            O_buffer   <= '0;
            O_rd_valid <= 1'b0;
            O_rd_data  <= 1'b0;
            O_pushed   <= 1'b0;
        end else begin
            O_rd_valid <= 1'b0;
            O_pushed   <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_cmd_valid) begin
                        case (cmd_e'(I_cmd))
                            CMD_SET:       draw[I_y][bit_idx] <= 1'b1;
                            CMD_CLR:       draw[I_y][bit_idx] <= 1'b0;
                            CMD_READ: begin
                                O_rd_valid <= 1'b1;
                                O_rd_data  <= draw[I_y][bit_idx];
                            end
                            CMD_CLEAR_ALL: state <= CLEAR;
                            CMD_PUSH: begin
                                if (SYNC_PUSH) state <= WAIT_VBL;
                                else           state <= COPY;
                            end
                            default: ;
                        endcase
                    end
                end
                CLEAR: begin
                    draw[row] <= '0;
                    if (row_wrap) state <= IDLE;
                end
                WAIT_VBL: begin
                    if (I_vblank) state <= COPY;
                end
                COPY: begin
                    O_buffer[row] <= draw[row];
                    if (row_wrap) begin
                        state    <= IDLE;
                        O_pushed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/screen_buffer_ctrl.md
SCREEN_BUFFER_CTRL -- requirements
Module: screen_buffer_ctrl

Interface
REQ-001 SHALL have parameter SYNC_PUSH, default 1: 1 = PUSH waits for vertical blank; 0 = PUSH starts immediately.
REQ-002 SHALL have port I_pxl_clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port I_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port I_cmd_valid, input, 1: command request.
REQ-005 SHALL have port O_cmd_ready, output, 1: controller accepts a command this cycle.
REQ-006 SHALL have port I_cmd, input, 3: 0 NOP, 1 SET, 2 CLR, 3 READ, 4 CLEAR_ALL, 5 PUSH; 6 and 7 are treated as NOP.
REQ-007 SHALL have ports I_x and I_y, input, 5 each: pixel column and row.
REQ-008 SHALL have port I_vblank, input, 1: high during vertical blanking of the display timing.
REQ-009 SHALL have port O_rd_valid, output, 1: one-cycle pulse, read data valid.
REQ-010 SHALL have port O_rd_data, output, 1: read pixel value.
REQ-011 SHALL have port O_buffer, output, 32 rows x 32 bits: registered display buffer feeding the screen driver.
REQ-012 SHALL have port O_busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port O_pushed, output, 1: one-cycle pulse when a copy completes.

Function
REQ-014 SHALL hold an internal 32x32-bit draw buffer; pixel (x,y) maps to row y, bit 31-x (bit 31 is leftmost).
REQ-015 SHALL accept a command on a cycle where I_cmd_valid and O_cmd_ready are both high; O_cmd_ready = (state == IDLE).
REQ-016 SHALL use FSM states IDLE, CLEAR, WAIT_VBL, COPY.
REQ-017 SET/CLR SHALL write 1/0 to the addressed draw bit on the accept edge; the FSM stays in IDLE.
REQ-018 READ SHALL drive O_rd_data with the draw-buffer bit and pulse O_rd_valid exactly one cycle after accept; O_rd_data holds its value until the next READ.
REQ-019 CLEAR_ALL SHALL move to CLEAR and zero draw rows 0..31, one row per cycle (32 cycles), then return to IDLE.
REQ-020 PUSH with SYNC_PUSH=1 SHALL enter WAIT_VBL, then enter COPY on the first cycle with I_vblank high; if I_vblank is already high at accept, COPY starts on the next cycle.
REQ-021 PUSH with SYNC_PUSH=0 SHALL enter COPY directly.
REQ-022 COPY SHALL copy draw row r to O_buffer row r for r = 0..31, one row per cycle; it SHALL continue to completion even if I_vblank falls mid-copy.
REQ-023 On the 5-bit row counter wrapping from 31 to 0, the FSM SHALL return to IDLE and pulse O_pushed (COPY only) in the same cycle.
REQ-024 The draw buffer SHALL be unchanged by COPY; O_buffer SHALL change only during COPY or reset.
REQ-025 NOP and reserved codes SHALL be accepted with no state change.
REQ-026 A command presented while O_cmd_ready is low SHALL NOT be accepted and SHALL have no effect; the requester holds it.

Reset
REQ-027 Asserting I_rst_n low SHALL immediately force: state IDLE, row counter 0, draw buffer all 0, O_buffer all 0, O_rd_valid 0, O_rd_data 0, O_pushed 0, O_busy 0, O_cmd_ready 1.
REQ-028 Reset asserted mid-CLEAR or mid-COPY SHALL abort the operation; no partial result is retained.

Structure
REQ-029 Command encodings, ROWS=32, COLS=32 and FSM state encodings SHALL live in the shared package screen_pkg.
REQ-030 The row counter with its wrap/done flag SHALL be a sub-module, scr_row_seq, reused by CLEAR and COPY.

Verification
REQ-031 SET (3,5), then READ (3,5) -> O_rd_valid high one cycle after accept with O_rd_data=1; READ (4,5) -> 0.
REQ-032 SET (0,0), PUSH with I_vblank=1, SYNC_PUSH=1 -> O_busy high 33 cycles; O_buffer[0]=32'h8000_0000; O_pushed pulses once.
REQ-033 PUSH with I_vblank=0 held 100 cycles -> O_buffer unchanged and O_cmd_ready=0 throughout; I_vblank rises -> copy completes 32 cycles later.
REQ-034 Fill all pixels, CLEAR_ALL -> O_cmd_ready low 32 cycles; all draw rows 0; O_buffer unchanged.
REQ-035 Assert I_rst_n low at COPY row 16 -> all O_buffer rows 0, state IDLE, O_pushed never pulses.
REQ-036 Hold I_cmd_valid with SET (31,31) during CLEAR -> command accepted in the first IDLE cycle; bit 0 of draw row 31 = 1.
